clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//   Display-mode sequencer for the digital clock. Debounces the MODE push-button and steps
//   through TIME -> STOPWATCH -> ALARMSET -> TIME, with an inactivity timeout out of ALARMSET.
//   Drives the ALARMSET_RUN/STOPWATCH_RUN selects of the 4-bit digit mux (MuxB4).
//   Outputs are always mutually exclusive, so the mux never sees an illegal select pair.
// PARAMETERS
//   DEBOUNCE_CYC  1000  consecutive CLK cycles a synchronized key level must hold to be accepted (>=1)
//   TIMEOUT_SEC   30    TICK_1HZ pulses of inactivity in ALARMSET before returning to TIME; 0 = no timeout
// PORTS
//   CLK            in   1  system clock, all logic on rising edge
//   RST            in   1  synchronous, active-high reset
//   MODE_KEY       in   1  raw MODE button, asynchronous, high = pressed
//   SET_ACT        in   1  1-cycle pulse: any alarm-setting edit (restarts the timeout)
//   TICK_1HZ       in   1  1-cycle pulse once per second from the timebase
//   ALARMSET_RUN   out  1  high only in ALARMSET
//   STOPWATCH_RUN  out  1  high only in STOPWATCH
//   MODE           out  2  state code: 00 TIME, 01 STOPWATCH, 10 ALARMSET (11 never driven)
//   MODE_CHG       out  1  1-cycle pulse on the cycle the MODE register takes a new value
// BEHAVIOUR
//   Reset (RST=1 at an edge): MODE=00, ALARMSET_RUN=0, STOPWATCH_RUN=0, MODE_CHG=0.
//     Sync flops=0, debounced level=0, debounce counter=0, timeout counter=0.
//     RST mid-debounce or mid-timeout discards all partial counts.
//   Input synchronizer: MODE_KEY passes through 2 flops (s1, s2).
//   Debounce:
//     - Counter increments while s2 != stable level; it clears on any cycle where s2 == stable.
//     - When the counter reaches DEBOUNCE_CYC, stable takes s2 and the counter clears.
//     - A 0->1 change of stable produces one internal press pulse in that same cycle.
//     - The release (1->0) is debounced the same way and produces no pulse.
//     - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
//   Latency: MODE_KEY held high from the edge at which it is first sampled (edge 0).
//     MODE/selects/MODE_CHG update at edge DEBOUNCE_CYC+3.
//     Holding the key produces exactly one step; it must be released and re-pressed to step again.
//   FSM, registered outputs decoded from the state:
//     TIME      --press--> STOPWATCH
//     STOPWATCH --press--> ALARMSET
//     ALARMSET  --press or timeout--> TIME
//     No other transitions. Illegal code 11 recovers to TIME on the next edge with MODE_CHG=1.
//   Timeout counter (width clog2(TIMEOUT_SEC+1)):
//     - Active only in ALARMSET. Cleared on entry to ALARMSET and in all other states.
//     - SET_ACT=1 clears it. If SET_ACT and TICK_1HZ are high in the same cycle, the clear wins.
//     - Otherwise TICK_1HZ increments it.
//     - Timeout fires on the cycle the incremented value equals TIMEOUT_SEC; the state goes to TIME
//       at that edge. It saturates and never wraps.
//     - TIMEOUT_SEC=0: the counter is held at 0 and no timeout ever fires.
//   Simultaneous press and timeout in ALARMSET: a single transition to TIME with one MODE_CHG pulse.
//   ALARMSET_RUN and STOPWATCH_RUN are never both 1 in any cycle, including reset and recovery.
// TESTING (bench params DEBOUNCE_CYC=4, TIMEOUT_SEC=3)
//   1 RST=1 for 2 edges, then 0 -> MODE=00, both selects 0, MODE_CHG=0.
//     No change for 50 cycles with the key idle.
//   2 MODE_KEY high 3 cycles, then low -> no state change (glitch rejected).
//     MODE_KEY held 20 cycles -> MODE=01, STOPWATCH_RUN=1 at edge 7 after the first sample.
//     MODE_CHG is high for exactly 1 cycle and there is only one step.
//   3 Three clean press/release pairs from TIME -> MODE sequence 01,10,00.
//     Selects are (STW=1,ALM=0), (0,1), (0,0). Three MODE_CHG pulses.
//   4 In ALARMSET, send 3 TICK_1HZ pulses with no SET_ACT -> MODE=00 at the edge of the 3rd tick.
//     Repeat with SET_ACT coincident with tick 2 -> still ALARMSET after 3 ticks;
//     returns to TIME after 3 further ticks.
//   5 In ALARMSET, align a debounced press with the 3rd tick -> single transition to 00,
//     one MODE_CHG pulse, never MODE=01.
//   6 Assert RST during STOPWATCH with a press half-debounced -> MODE=00 next edge.
//     After release, no stray step occurs. Every cycle, check !(ALARMSET_RUN & STOPWATCH_RUN).

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: debounced MODE-button sequencer TIME -> STOPWATCH -> ALARMSET,
// with an inactivity timeout out of ALARMSET and mutually exclusive mux selects.
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int TIMEOUT_SEC  = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE_KEY,
    input  logic       SET_ACT,
    input  logic       TICK_1HZ,
    output logic       ALARMSET_RUN,
    output logic       STOPWATCH_RUN,
    output logic [1:0] MODE,
    output logic       MODE_CHG
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = TIMEOUT_SEC > 0 ? $clog2(TIMEOUT_SEC + 1) : 1;

    typedef enum logic [1:0] {TIME = 2'b00, STOPWATCH = 2'b01, ALARMSET = 2'b10} state_t;

    state_t        state, nxt;
    logic          s1, s2, stable, press, timeout;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] to_cnt;

    assign MODE = state;

    // Timeout fires when the tick would bring the idle count up to TIMEOUT_SEC; SET_ACT masks it.
    assign timeout = TIMEOUT_SEC != 0 && state == ALARMSET && TICK_1HZ && !SET_ACT &&
                     {1'b0, to_cnt} + (TW+1)'(1) == (TW+1)'(TIMEOUT_SEC);

    always_comb begin
        nxt = state == TIME      ? (press ? STOPWATCH : TIME) :
              state == STOPWATCH ? (press ? ALARMSET : STOPWATCH) :
              state == ALARMSET  ? (press || timeout ? TIME : ALARMSET) : TIME;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            stable        <= 1'b0;
            press         <= 1'b0;
            db_cnt        <= '0;
            to_cnt        <= '0;
            state         <= TIME;
            ALARMSET_RUN  <= 1'b0;
            STOPWATCH_RUN <= 1'b0;
            MODE_CHG      <= 1'b0;
        end else begin
            s1    <= MODE_KEY;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == stable)
                db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYC)) begin
                stable <= s2;
                db_cnt <= '0;
                press  <= s2;
            end else
                db_cnt <= db_cnt + DW'(1);
            state         <= nxt;
            ALARMSET_RUN  <= nxt == ALARMSET;
            STOPWATCH_RUN <= nxt == STOPWATCH;
            MODE_CHG      <= nxt != state;
            // Cleared outside ALARMSET, on entry and exit, and on any edit.
            if (state != ALARMSET || nxt != ALARMSET || SET_ACT || TIMEOUT_SEC == 0)
                to_cnt <= '0;
            else if (TICK_1HZ && to_cnt != TW'(TIMEOUT_SEC))
                to_cnt <= to_cnt + TW'(1);
        end
    end
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed and randomized checks of clock_mode_ctrl against a
// behavioural model of debounce, mode stepping and ALARMSET inactivity timeout.
module tb_clock_mode_ctrl;
    localparam int D = 4;
    localparam int T = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1, MODE_KEY = 1'b0, SET_ACT = 1'b0, TICK_1HZ = 1'b0;
    logic       ALARMSET_RUN, STOPWATCH_RUN, MODE_CHG;
    logic [1:0] MODE;

    int tests = 0, fails = 0;
    int m1, m2, lvl, run, pend, e_mode, secs, e_chg;

    clock_mode_ctrl #(.DEBOUNCE_CYC(D), .TIMEOUT_SEC(T)) dut (
        .CLK(CLK), .RST(RST), .MODE_KEY(MODE_KEY), .SET_ACT(SET_ACT), .TICK_1HZ(TICK_1HZ),
        .ALARMSET_RUN(ALARMSET_RUN), .STOPWATCH_RUN(STOPWATCH_RUN), .MODE(MODE), .MODE_CHG(MODE_CHG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the key is seen two edges late; a new level is accepted once it has
    // differed from the accepted level for more than D consecutive edges; a press steps
    // the mode one edge after acceptance; ALARMSET counts idle seconds up to T.
    task automatic model();
        int old, press_now, tmo;
        if (RST) begin
            m1 = 0; m2 = 0; lvl = 0; run = 0; pend = 0; e_mode = 0; secs = 0; e_chg = 0;
        end else begin
            press_now = pend;
            tmo = (e_mode == 2 && !SET_ACT && TICK_1HZ && T != 0 && secs + 1 == T);
            old = e_mode;
            if (e_mode == 2 && (press_now || tmo)) e_mode = 0;
            else if (press_now) e_mode = (e_mode + 1) % 3;
            e_chg = (e_mode != old);
            if (old != 2 || e_mode != 2 || SET_ACT) secs = 0;
            else if (TICK_1HZ && secs < T) secs++;
            pend = 0;
            if (m2 == lvl) run = 0;
            else begin
                run++;
                if (run > D) begin
                    lvl = m2; run = 0; pend = lvl;
                end
            end
            m2 = m1;
            m1 = MODE_KEY;
        end
    endtask

    task automatic step(input logic r, input logic k, input logic s, input logic t);
        RST = r; MODE_KEY = k; SET_ACT = s; TICK_1HZ = t;
        @(posedge CLK);
        model();
        #1;
        chk("mode", MODE, e_mode);
        chk("stw_run", STOPWATCH_RUN, e_mode == 1);
        chk("alm_run", ALARMSET_RUN, e_mode == 2);
        chk("mode_chg", MODE_CHG, e_chg);
        chk("exclusive", ALARMSET_RUN & STOPWATCH_RUN, 0);
    endtask

    task automatic press(input logic [1:0] want);
        repeat (8) step(0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        chk("press_mode", MODE, want);
    endtask

    task automatic tick_gap();
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_mode", MODE, 0);
        repeat (50) step(0, 0, 0, 0);
        chk("idle_mode", MODE, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        chk("glitch", MODE, 0);
        repeat (7) step(0, 1, 0, 0);
        chk("lat_e6", MODE, 0);
        step(0, 1, 0, 0);
        chk("lat_e7", MODE, 1);
        chk("lat_chg", MODE_CHG, 1);
        repeat (12) step(0, 1, 0, 0);
        chk("hold_one", MODE, 1);
        repeat (10) step(0, 0, 0, 0);
        press(2); press(0); press(1); press(2);
        repeat (3) tick_gap();
        chk("timeout", MODE, 0);
        press(1); press(2);
        tick_gap();
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0);
        tick_gap();
        chk("set_restart", MODE, 2);
        repeat (3) tick_gap();
        chk("timeout2", MODE, 0);
        press(1); press(2);
        tick_gap(); tick_gap();
        repeat (7) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("press_tmo_mode", MODE, 0);
        chk("press_tmo_chg", MODE_CHG, 1);
        repeat (10) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        chk("press_tmo_after", MODE, 0);
        press(1);
        repeat (4) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_mid", MODE, 0);
        repeat (20) step(0, 0, 0, 0);
        chk("no_stray", MODE, 0);
        for (int p = 0; p < 400; p++) begin
            logic k;
            k = p[0];
            repeat ($urandom_range(1, 12))
                step($urandom_range(0, 299) == 0, k, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
